// File: rtl/dht_request_ctrl.sv
`timescale 1ns/1ps
// dht_request_ctrl
// Request sequencer between the host command path and the 32-channel DHT11
// reader. Takes one request at a time, pulses the reader's start and waits for
// done (with a timeout). It then grades the result and streams a 2-byte
// response frame out on a valid/ready byte interface.
module dht_request_ctrl #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_sensor,
  input  logic [1:0] req_cmd,
  output logic       start_bit,
  output logic [4:0] sensorIndex,
  input  logic       dht_done,
  input  logic       dht_error,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
  input  logic [7:0] check_sum,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  // Last counter value seen in WAIT_DONE before the timeout fires.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_OK      = 3'b000;
  localparam logic [2:0] ST_DHT_ERR = 3'b001;
  localparam logic [2:0] ST_CKSUM   = 3'b010;
  localparam logic [2:0] ST_TIMEOUT = 3'b011;
  localparam logic [2:0] ST_BAD_CMD = 3'b100;

  localparam logic [1:0] CMD_STATUS = 2'd0;
  localparam logic [1:0] CMD_HUM    = 2'd1;
  localparam logic [1:0] CMD_BAD    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_EVAL,
    S_LOAD,
    S_SEND0,
    S_SEND1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start_bit;
  logic [4:0]       r_sensor;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;

  // Request / result context; only meaningful while a request is in flight.
  logic [1:0]       r_cmd;
  logic [2:0]       r_status;
  logic             r_err;
  logic [7:0]       r_hum_int;
  logic [7:0]       r_hum_float;
  logic [7:0]       r_temp_int;
  logic [7:0]       r_temp_float;
  logic [7:0]       r_check_sum;

  logic [7:0]       w_byte0;
  logic [7:0]       w_byte1;

  // DHT11 checksum: plain byte sum of the four data bytes, carries dropped.
  function automatic logic [7:0] f_checksum(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d);
    return a + b + c + d;
  endfunction

  // Reader error outranks a checksum mismatch.
  function automatic logic [2:0] f_eval_status(input logic err, input logic [7:0] sum,
                                               input logic [7:0] ck);
    if (err)
      return ST_DHT_ERR;
    else if (sum != ck)
      return ST_CKSUM;
    else
      return ST_OK;
  endfunction

  // Second frame byte: payload only for a clean humidity/temperature read.
  function automatic logic [7:0] f_payload(input logic [2:0] status, input logic [1:0] cmd,
                                           input logic [7:0] hum, input logic [7:0] temp);
    if (status != ST_OK || cmd == CMD_STATUS)
      return 8'h00;
    else if (cmd == CMD_HUM)
      return hum;
    else
      return temp;
  endfunction

  assign w_byte0     = {r_status, r_sensor};
  assign w_byte1     = f_payload(r_status, r_cmd, r_hum_int, r_temp_int);

  assign req_ready   = (r_state == S_IDLE) && !rst;
  assign start_bit   = r_start_bit;
  assign sensorIndex = r_sensor;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;

  // Request FSM: accept, start pulse, wait/timeout, grade, then send the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_start_bit <= 1'b0;
      r_sensor    <= 5'd0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
    end else begin
      // start_bit is high only in the cycle spent in START.
      r_start_bit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_sensor <= req_sensor;
            r_cmd    <= req_cmd;
            if (req_cmd == CMD_BAD) begin
              r_status <= ST_BAD_CMD;
              r_state  <= S_LOAD;
            end else begin
              r_start_bit <= 1'b1;
              r_state     <= S_START;
            end
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          r_cnt <= r_cnt + 1'b1;
          // A done on the timeout cycle still counts as a result.
          if (dht_done) begin
            r_err        <= dht_error;
            r_hum_int    <= hum_int;
            r_hum_float  <= hum_float;
            r_temp_int   <= temp_int;
            r_temp_float <= temp_float;
            r_check_sum  <= check_sum;
            r_state      <= S_EVAL;
          end else if (r_cnt == TO_LAST) begin
            r_status <= ST_TIMEOUT;
            r_state  <= S_LOAD;
          end
        end
        S_EVAL: begin
          r_status <= f_eval_status(r_err,
                                    f_checksum(r_hum_int, r_hum_float, r_temp_int, r_temp_float),
                                    r_check_sum);
          r_state  <= S_LOAD;
        end
        S_LOAD: begin
          r_tx_data  <= w_byte0;
          r_tx_valid <= 1'b1;
          r_state    <= S_SEND0;
        end
        S_SEND0: begin
          if (tx_ready) begin
            r_tx_data <= w_byte1;
            r_state   <= S_SEND1;
          end
        end
        S_SEND1: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
